ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the issue-execute pipeline register and the EX-stage datapath.
//  Detects load-use hazards, sequences multi-cycle MULT/DIV ops occupying EX, squashes on taken branch.
//  Drives IF/ID stalls, EX-register clear/hold and EX operand forwarding selects.
// PARAMETERS
//  MULT_OP   6'h18  alu_op code of multiply (multi-cycle)
//  DIV_OP    6'h1A  alu_op code of divide (multi-cycle)
//  MD_LAT    8      total cycles a MULT/DIV occupies EX; legal range 3..255
// PORTS
//  clk             in   1  clock
//  reset           in   1  asynchronous, active-high reset
//  valid_id_i      in   1  ID-stage instruction valid
//  rs_id_i         in   5  ID source reg rs
//  rt_id_i         in   5  ID source reg rt
//  branch_taken_i  in   1  branch in ID resolved taken
//  valid_ex_i      in   1  EX-stage instruction valid
//  mem_to_reg_ex_i in   1  EX instruction is a load
//  alu_op_ex_i     in   6  EX alu op
//  rs_ex_i         in   5  EX source reg rs
//  rt_ex_i         in   5  EX source reg rt
//  dst_ex_i        in   5  EX resolved destination (after reg_dst mux)
//  reg_wr_mem_i    in   1  MEM instruction writes register file
//  dst_mem_i       in   5  MEM destination
//  reg_wr_wb_i     in   1  WB instruction writes register file
//  dst_wb_i        in   5  WB destination
//  stall_if_o      out  1  hold PC
//  stall_id_o      out  1  hold IF/ID register
//  stall_ex_o      out  1  hold ID/EX register (enable low)
//  clr_ex_o        out  1  clear ID/EX register (bubble)
//  flush_id_o      out  1  clear IF/ID register
//  fwd_a_o         out  2  rs operand select: 00 regfile, 01 WB, 10 MEM
//  fwd_b_o         out  2  rt operand select, same encoding
//  md_busy_o       out  1  MULT/DIV sequencer not IDLE
//  md_done_o       out  1  one-cycle pulse: final EX cycle of MULT/DIV
// BEHAVIOUR
//  - FSM states IDLE, BUSY, DONE; 8-bit down-counter cnt. Reset: state IDLE, cnt 0; async reset mid-op aborts to IDLE.
//  - md_start = state==IDLE & valid_ex_i & (alu_op_ex_i==MULT_OP | alu_op_ex_i==DIV_OP).
//  - IDLE: md_start -> BUSY, cnt<=MD_LAT-3. BUSY: cnt==0 -> DONE else cnt--. DONE -> IDLE unconditionally.
//  - md_stall = md_start | state==BUSY; op occupies EX exactly MD_LAT cycles (1 IDLE + MD_LAT-2 BUSY + 1 DONE).
//  - md_busy_o = state!=IDLE; md_done_o = state==DONE. MD op in EX during DONE is not re-detected.
//  - load_use = valid_ex_i & mem_to_reg_ex_i & dst_ex_i!=0 & valid_id_i & (dst_ex_i==rs_id_i | dst_ex_i==rt_id_i).
//  - Priority md_stall > load_use > branch_taken_i:
//      md_stall: stall_if=stall_id=stall_ex=1, clr_ex=0, flush_id=0.
//      load_use: stall_if=stall_id=1, clr_ex=1 (one bubble), flush_id=0.
//      branch_taken_i only: flush_id=1, no stalls.
//  - Forwarding (combinational): fwd_a=10 if reg_wr_mem_i & dst_mem_i!=0 & dst_mem_i==rs_ex_i;
//    else 01 if reg_wr_wb_i & dst_wb_i!=0 & dst_wb_i==rs_ex_i; else 00. fwd_b identical on rt_ex_i. MEM wins over WB.
//  - Register $0 never forwarded, never causes stall. Stall/flush outputs are combinational, same cycle as hazard.
//  - While reset high every output is 0.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs lu_stall_cnt_o[31:0], md_stall_cnt_o[31:0]; increment each cycle
//    load_use (not masked by md_stall) / md_stall is high; reset to 0; wrap 32'hFFFFFFFF->0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. lw dst=5 in EX, ID reads rs=5 -> stall_if/id=1, clr_ex=1 for 1 cycle; dst=0 -> no stall.
//  2. MULT in EX, MD_LAT=8 -> stall_ex=1 for 7 cycles, md_done_o pulse on 8th, md_busy_o high cycles 2-8.
//  3. Back-to-back MULT,DIV -> two 8-cycle occupancies, no gap cycle, two md_done pulses.
//  4. MEM dst=3 and WB dst=3, rs_ex=3 -> fwd_a=10; MEM dst=0 -> fwd_a=01; both miss -> 00.
//  5. branch_taken_i with load-use present -> flush_id=0, bubble first; alone -> flush_id=1.
//  6. reset asserted at BUSY cnt=3 -> md_busy_o=0 immediately; with HAZARD_STATS_EN, counters read 0.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard and sequencing controller for the ID/EX pipeline register
// and the EX-stage datapath.
//  - Detects load-use hazards and inserts one bubble.
//  - Sequences multi-cycle MULT/DIV ops, which occupy EX for MD_LAT cycles.
//  - Flushes IF/ID on a taken branch.
//  - Produces EX operand forwarding selects.
// Optional feature: define HAZARD_STATS_EN to add free-running stall counters
// (lu_stall_cnt_o, md_stall_cnt_o).
module ex_hazard_ctrl #(
    parameter logic [5:0] MULT_OP = 6'h18,
    parameter logic [5:0] DIV_OP  = 6'h1A,
    parameter int         MD_LAT  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_id_i,
    input  logic [4:0] rs_id_i,
    input  logic [4:0] rt_id_i,
    input  logic       branch_taken_i,
    input  logic       valid_ex_i,
    input  logic       mem_to_reg_ex_i,
    input  logic [5:0] alu_op_ex_i,
    input  logic [4:0] rs_ex_i,
    input  logic [4:0] rt_ex_i,
    input  logic [4:0] dst_ex_i,
    input  logic       reg_wr_mem_i,
    input  logic [4:0] dst_mem_i,
    input  logic       reg_wr_wb_i,
    input  logic [4:0] dst_wb_i,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       stall_ex_o,
    output logic       clr_ex_o,
    output logic       flush_id_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       md_busy_o,
    output logic       md_done_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] lu_stall_cnt_o,
    output logic [31:0] md_stall_cnt_o
`endif
);

    // The first EX cycle is spent in IDLE and the last in DONE, so BUSY covers MD_LAT-2
    // cycles. The counter therefore starts at MD_LAT-3 and counts down to 0.
    localparam logic [7:0] MD_INIT = 8'(MD_LAT - 3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    md_state_t  r_state;
    logic [7:0] r_cnt;

    logic w_is_md_op;
    logic w_md_start;
    logic w_md_stall;
    logic w_load_use;

    assign w_is_md_op = (alu_op_ex_i == MULT_OP) || (alu_op_ex_i == DIV_OP);
    // Only IDLE can launch an op, so the MD op still sitting in EX during DONE is not
    // picked up a second time.
    assign w_md_start = (r_state == ST_IDLE) && valid_ex_i && w_is_md_op;
    assign w_md_stall = w_md_start || (r_state == ST_BUSY);
    assign w_load_use = valid_ex_i && mem_to_reg_ex_i && (dst_ex_i != 5'd0) && valid_id_i &&
                        ((dst_ex_i == rs_id_i) || (dst_ex_i == rt_id_i));

    // MULT/DIV occupancy sequencer; reset aborts any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_md_start) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= MD_INIT;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stall/flush priority (MD > load-use > branch) and operand forwarding (MEM over WB);
    // every output is held at 0 while reset is high.
    always_comb begin
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        stall_ex_o = 1'b0;
        clr_ex_o   = 1'b0;
        flush_id_o = 1'b0;
        fwd_a_o    = 2'b00;
        fwd_b_o    = 2'b00;
        md_busy_o  = 1'b0;
        md_done_o  = 1'b0;
        if (!reset) begin
            md_busy_o = (r_state != ST_IDLE);
            md_done_o = (r_state == ST_DONE);
            if (w_md_stall) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                stall_ex_o = 1'b1;
            end else if (w_load_use) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                clr_ex_o   = 1'b1;
            end else if (branch_taken_i) begin
                flush_id_o = 1'b1;
            end

            if (reg_wr_mem_i && (dst_mem_i != 5'd0) && (dst_mem_i == rs_ex_i)) begin
                fwd_a_o = 2'b10;
            end else if (reg_wr_wb_i && (dst_wb_i != 5'd0) && (dst_wb_i == rs_ex_i)) begin
                fwd_a_o = 2'b01;
            end

            if (reg_wr_mem_i && (dst_mem_i != 5'd0) && (dst_mem_i == rt_ex_i)) begin
                fwd_b_o = 2'b10;
            end else if (reg_wr_wb_i && (dst_wb_i != 5'd0) && (dst_wb_i == rt_ex_i)) begin
                fwd_b_o = 2'b01;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_lu_cnt;
    logic [31:0] r_md_cnt;

    // Cycle counters for load-use (counted even when masked by an MD stall) and MD stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lu_cnt <= 32'd0;
            r_md_cnt <= 32'd0;
        end else begin
            if (w_load_use) r_lu_cnt <= r_lu_cnt + 32'd1;
            if (w_md_stall) r_md_cnt <= r_md_cnt + 32'd1;
        end
    end

    assign lu_stall_cnt_o = r_lu_cnt;
    assign md_stall_cnt_o = r_md_cnt;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed-vector bench for ex_hazard_ctrl (MD_LAT = 8).
module tb_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_id_i;
    logic [4:0] rs_id_i;
    logic [4:0] rt_id_i;
    logic       branch_taken_i;
    logic       valid_ex_i;
    logic       mem_to_reg_ex_i;
    logic [5:0] alu_op_ex_i;
    logic [4:0] rs_ex_i;
    logic [4:0] rt_ex_i;
    logic [4:0] dst_ex_i;
    logic       reg_wr_mem_i;
    logic [4:0] dst_mem_i;
    logic       reg_wr_wb_i;
    logic [4:0] dst_wb_i;
    logic       stall_if_o;
    logic       stall_id_o;
    logic       stall_ex_o;
    logic       clr_ex_o;
    logic       flush_id_o;
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;
    logic       md_busy_o;
    logic       md_done_o;
`ifdef HAZARD_STATS_EN
    logic [31:0] lu_stall_cnt_o;
    logic [31:0] md_stall_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // {stall_if, stall_id, stall_ex, clr_ex, flush_id}
    logic [4:0]  ctl;
    // every output packed: ctl, fwd_a, fwd_b, md_busy, md_done
    logic [10:0] all_o;
    assign ctl   = {stall_if_o, stall_id_o, stall_ex_o, clr_ex_o, flush_id_o};
    assign all_o = {ctl, fwd_a_o, fwd_b_o, md_busy_o, md_done_o};

    ex_hazard_ctrl #(.MULT_OP(6'h18), .DIV_OP(6'h1A), .MD_LAT(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_id_i      (valid_id_i),
        .rs_id_i         (rs_id_i),
        .rt_id_i         (rt_id_i),
        .branch_taken_i  (branch_taken_i),
        .valid_ex_i      (valid_ex_i),
        .mem_to_reg_ex_i (mem_to_reg_ex_i),
        .alu_op_ex_i     (alu_op_ex_i),
        .rs_ex_i         (rs_ex_i),
        .rt_ex_i         (rt_ex_i),
        .dst_ex_i        (dst_ex_i),
        .reg_wr_mem_i    (reg_wr_mem_i),
        .dst_mem_i       (dst_mem_i),
        .reg_wr_wb_i     (reg_wr_wb_i),
        .dst_wb_i        (dst_wb_i),
        .stall_if_o      (stall_if_o),
        .stall_id_o      (stall_id_o),
        .stall_ex_o      (stall_ex_o),
        .clr_ex_o        (clr_ex_o),
        .flush_id_o      (flush_id_o),
        .fwd_a_o         (fwd_a_o),
        .fwd_b_o         (fwd_b_o),
        .md_busy_o       (md_busy_o),
        .md_done_o       (md_done_o)
`ifdef HAZARD_STATS_EN
        ,
        .lu_stall_cnt_o  (lu_stall_cnt_o),
        .md_stall_cnt_o  (md_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        valid_id_i      = 1'b0;
        rs_id_i         = 5'd0;
        rt_id_i         = 5'd0;
        branch_taken_i  = 1'b0;
        valid_ex_i      = 1'b0;
        mem_to_reg_ex_i = 1'b0;
        alu_op_ex_i     = 6'h00;
        rs_ex_i         = 5'd0;
        rt_ex_i         = 5'd0;
        dst_ex_i        = 5'd0;
        reg_wr_mem_i    = 1'b0;
        dst_mem_i       = 5'd0;
        reg_wr_wb_i     = 1'b0;
        dst_wb_i        = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_nop();
        // hazards of every kind present; outputs must still be 0 under reset
        valid_ex_i = 1'b1; mem_to_reg_ex_i = 1'b1; dst_ex_i = 5'd5;
        valid_id_i = 1'b1; rs_id_i = 5'd5; branch_taken_i = 1'b1;
        reg_wr_mem_i = 1'b1; dst_mem_i = 5'd7; rs_ex_i = 5'd7;
        tick(); tick();
        n_cmp++;
        if (all_o !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want %b", all_o, 11'd0);
        end
        drive_nop();
        #2;
        reset = 1'b0;
        tick();
        n_cmp++;
        if (all_o !== 11'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b want %b", all_o, 11'd0);
        end
        $display("txn reset: outputs=%b", all_o);
    endtask

    task automatic test_load_use();
        // {valid_ex, mem_to_reg, dst_ex, valid_id, rs_id, rt_id, branch, expected ctl}
        logic [24:0] vec [7];
        vec[0] = {1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd9, 1'b0, 5'b11010}; // rs match
        vec[1] = {1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 5'd5, 1'b0, 5'b11010}; // rt match
        vec[2] = {1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'b00000}; // $0 dst
        vec[3] = {1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 5'b00000}; // EX invalid
        vec[4] = {1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 5'b00000}; // not a load
        vec[5] = {1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd1, 1'b1, 5'b11010}; // branch masked by bubble
        vec[6] = {1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 5'd1, 1'b1, 5'b00001}; // branch alone
        for (int i = 0; i < 7; i++) begin
            drive_nop();
            {valid_ex_i, mem_to_reg_ex_i, dst_ex_i, valid_id_i, rs_id_i, rt_id_i,
             branch_taken_i} = vec[i][24:5];
            #2;
            n_cmp++;
            if (ctl !== vec[i][4:0]) begin
                n_bad++;
                $display("FAIL load_use_%0d: ctl got %b want %b", i, ctl, vec[i][4:0]);
            end
            $display("txn load_use %0d: ctl=%b", i, ctl);
            tick();
        end
        drive_nop();
    endtask

    task automatic test_forward();
        // {wr_mem, dst_mem, wr_wb, dst_wb, rs_ex, rt_ex, exp fwd_a, exp fwd_b}
        logic [25:0] vec [6];
        vec[0] = {1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd4, 2'b10, 2'b00}; // MEM wins
        vec[1] = {1'b1, 5'd0, 1'b1, 5'd3, 5'd3, 5'd3, 2'b01, 2'b01}; // MEM $0 -> WB
        vec[2] = {1'b1, 5'd6, 1'b1, 5'd7, 5'd3, 5'd3, 2'b00, 2'b00}; // both miss
        vec[3] = {1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3, 2'b01, 2'b01}; // MEM no write
        vec[4] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00}; // $0 never forwarded
        vec[5] = {1'b1, 5'd8, 1'b1, 5'd9, 5'd9, 5'd8, 2'b01, 2'b10}; // split
        for (int i = 0; i < 6; i++) begin
            drive_nop();
            {reg_wr_mem_i, dst_mem_i, reg_wr_wb_i, dst_wb_i, rs_ex_i, rt_ex_i} = vec[i][25:4];
            #2;
            n_cmp++;
            if ({fwd_a_o, fwd_b_o} !== vec[i][3:0]) begin
                n_bad++;
                $display("FAIL forward_%0d: fwd_a/b got %b/%b want %b/%b", i, fwd_a_o, fwd_b_o,
                         vec[i][3:2], vec[i][1:0]);
            end
            $display("txn forward %0d: fwd_a=%b fwd_b=%b", i, fwd_a_o, fwd_b_o);
            tick();
        end
        drive_nop();
    endtask

    task automatic test_mult();
        drive_nop();
        valid_ex_i = 1'b1; alu_op_ex_i = 6'h18;
        for (int c = 1; c <= 9; c++) begin
            logic e_stall, e_busy, e_done;
            if (c == 9) drive_nop();
            #2;
            e_stall = (c <= 7);
            e_busy  = (c >= 2) && (c <= 8);
            e_done  = (c == 8);
            n_cmp++;
            if ({stall_if_o, stall_id_o, stall_ex_o, clr_ex_o, md_busy_o, md_done_o} !==
                {e_stall, e_stall, e_stall, 1'b0, e_busy, e_done}) begin
                n_bad++;
                $display("FAIL mult_cycle_%0d: stall_ex=%b busy=%b done=%b want %b %b %b",
                         c, stall_ex_o, md_busy_o, md_done_o, e_stall, e_busy, e_done);
            end
            $display("txn mult cycle %0d: stall_ex=%b busy=%b done=%b", c, stall_ex_o,
                     md_busy_o, md_done_o);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        drive_nop();
        valid_ex_i = 1'b1; alu_op_ex_i = 6'h18;
        for (int c = 1; c <= 17; c++) begin
            logic e_stall, e_done;
            if (c == 9)  alu_op_ex_i = 6'h1A;
            if (c == 17) drive_nop();
            #2;
            e_stall = (c <= 7) || (c >= 9 && c <= 15);
            e_done  = (c == 8) || (c == 16);
            if (md_done_o) dones++;
            n_cmp++;
            if ({stall_ex_o, md_done_o, md_busy_o} !== {e_stall, e_done, (c != 1 && c != 9 && c != 17)}) begin
                n_bad++;
                $display("FAIL b2b_cycle_%0d: stall_ex=%b done=%b busy=%b want %b %b %b", c,
                         stall_ex_o, md_done_o, md_busy_o, e_stall, e_done,
                         (c != 1 && c != 9 && c != 17));
            end
            $display("txn b2b cycle %0d: stall_ex=%b busy=%b done=%b", c, stall_ex_o,
                     md_busy_o, md_done_o);
            tick();
        end
        n_cmp++;
        if (dones !== 2) begin
            n_bad++;
            $display("FAIL b2b_done_count: got %0d want 2", dones);
        end
    endtask

    task automatic test_reset_mid_op();
        drive_nop();
        valid_ex_i = 1'b1; alu_op_ex_i = 6'h18;
        tick(); tick(); tick();   // now 4th cycle: BUSY with cnt == 3
        #2;
        n_cmp++;
        if (md_busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_op_busy: got %b want 1", md_busy_o);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (all_o !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_abort: outputs got %b want %b", all_o, 11'd0);
        end
`ifdef HAZARD_STATS_EN
        n_cmp++;
        if ({lu_stall_cnt_o, md_stall_cnt_o} !== 64'd0) begin
            n_bad++;
            $display("FAIL stats_reset: lu=%0d md=%0d want 0 0", lu_stall_cnt_o, md_stall_cnt_o);
        end
`endif
        $display("txn reset mid-op: busy=%b outputs=%b", md_busy_o, all_o);
        drive_nop();
        #2;
        reset = 1'b0;
        tick();
        #2;
        n_cmp++;
        if ({md_busy_o, stall_ex_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL after_abort_idle: busy=%b stall_ex=%b want 0 0", md_busy_o, stall_ex_o);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_mult();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
